neuron_accum: RTL

NEURON_ACCUM -- requirements
Module: neuron_accum

---
 rtl/nn_pkg.sv | 8 +
 rtl/requant_relu_sat.sv | 27 ++
 rtl/neuron_accum.sv | 86 ++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron accumulator datapath.
package nn_pkg;
  typedef enum logic [1:0] {ACCUM, FINISH, HOLD} state_t;
  typedef logic signed [7:0]  int8_t;
  typedef logic signed [15:0] int16_t;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
endpackage

// File: rtl/requant_relu_sat.sv
// Combinational requantization: arithmetic shift, optional ReLU, int8 saturation.
module requant_relu_sat
  import nn_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] s,
  output int8_t                   q
);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(INT8_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(INT8_MIN);

  logic signed [ACC_W-1:0] sh;
  logic signed [ACC_W-1:0] act;

  always_comb begin
    // >>> on a signed operand floors toward minus infinity
    sh  = s >>> SHIFT;
    act = sh;
    if (RELU != 0 && sh < 0) act = '0;
    if (act > HI)      q = int8_t'(INT8_MAX);
    else if (act < LO) q = int8_t'(INT8_MIN);
    else               q = act[7:0];
  end
endmodule

// File: rtl/neuron_accum.sv
// Single neuron: accumulates N_INPUTS products, adds bias, requantizes, holds result.
module neuron_accum
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 7,
  parameter int RELU     = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  int16_t product,
  input  int16_t bias,
  output logic   out_valid,
  input  logic   out_ready,
  output int8_t  y
);
  localparam int CNT_W = $clog2(N_INPUTS + 1);

  generate
    if (N_INPUTS < 1 || N_INPUTS > 256) begin : g_bad_n
      $error("neuron_accum: N_INPUTS out of range 1..256");
    end
    if (ACC_W < 16 + $clog2(N_INPUTS) + 1) begin : g_bad_w
      $error("neuron_accum: ACC_W too narrow for N_INPUTS");
    end
  endgenerate

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        count;
  int8_t                   q;
  logic                    accept;
  logic                    last;

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (count == CNT_W'(N_INPUTS - 1));
  assign sum       = acc + {{(ACC_W-16){bias[15]}}, bias};

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = FINISH;
      FINISH:  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // y is only written in FINISH, so it keeps the last result after the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      y     <= '0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          acc   <= acc + {{(ACC_W-16){product[15]}}, product};
          count <= count + CNT_W'(1);
        end
        FINISH: y <= q;
        HOLD: if (out_ready) begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

  requant_relu_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(RELU)) u_rq (
    .s (sum),
    .q (q)
  );
endmodule
